tnn_feature_packer: RTL and testbench

//  Front-end driver for the combinational 6x3-bit TNN approximate classifier cores.
//  - Accepts a valid/ready stream of raw sensor features and quantises each to 3 bits.
//  - Packs six features into one 18-bit vector and holds it stable while the core settles.
//  - Samples the core's 1-bit decision and returns it on a valid/ready result channel.

---
 rtl/tnn_feature_packer.sv | 111 +++++++++++
 tb/tb_tnn_feature_packer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_packer.sv
// Quantising valid/ready front end for the 6x3-bit TNN classifier cores.
// Define TNN_PACKER_ROUND_EN for round-to-nearest quantisation (default: truncation).
module tnn_feature_packer #(
  parameter int IN_W        = 8,
  parameter int NFEAT       = 6,
  parameter int EVAL_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_W-1:0]    s_data,
  input  logic               s_last,
  output logic [3*NFEAT-1:0] feat_vec,
  input  logic               core_result,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_class,
  output logic               m_err
);

  localparam logic [2:0] LAST_IDX = 3'(NFEAT - 1);
  localparam logic [2:0] EVAL_END = 3'(EVAL_CYCLES);

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    OUTPUT
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [2:0] ecnt;
  logic [2:0] q_data;
  logic       frame_end;

  function automatic logic [2:0] quant(
    input logic [IN_W-1:0] d
  );
`ifdef TNN_PACKER_ROUND_EN
    logic [IN_W:0] half;
    logic [IN_W:0] sum;
    logic [IN_W:0] sh;
    half = (IN_W+1)'(1) << (IN_W - 4);
    sum  = {1'b0, d} + half;
    sh   = sum >> (IN_W - 3);
    if (sh > (IN_W+1)'(7))
      quant = 3'd7;
    else
      quant = 3'(sh);
`else
    quant = 3'(d >> (IN_W - 3));
`endif
  endfunction

  assign q_data    = quant(s_data);
  assign s_ready   = (state == COLLECT);
  assign frame_end = s_last || (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      idx      <= 3'd0;
      ecnt     <= 3'd0;
      feat_vec <= '0;
      m_valid  <= 1'b0;
      m_class  <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (s_valid) begin
            // Short frames zero the unused upper slots on the same edge.
            for (int k = 0; k < NFEAT; k++) begin
              if (3'(k) == idx)
                feat_vec[3*k +: 3] <= q_data;
              else if (s_last && (3'(k) > idx))
                feat_vec[3*k +: 3] <= 3'd0;
            end
            if (frame_end) begin
              state <= EVAL;
              ecnt  <= 3'd0;
              m_err <= s_last ^ (idx == LAST_IDX);
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        EVAL: begin
          if (ecnt == EVAL_END) begin
            m_class <= core_result;
            m_valid <= 1'b1;
            state   <= OUTPUT;
          end else begin
            ecnt <= ecnt + 3'd1;
          end
        end
        OUTPUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            idx     <= 3'd0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Bench for tnn_feature_packer: timestamped frame model plus directed
// literal checks, then randomized stream traffic.
module tb_tnn_feature_packer;

  localparam int IN_W  = 8;
  localparam int NFEAT = 6;
  localparam int EVC   = 1;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [IN_W-1:0]   s_data;
  logic              s_last;
  logic [3*NFEAT-1:0] feat_vec;
  logic              core_result;
  logic              m_valid;
  logic              m_ready;
  logic              m_class;
  logic              m_err;

  int total;
  int bad;

  tnn_feature_packer #(
    .IN_W(IN_W),
    .NFEAT(NFEAT),
    .EVAL_CYCLES(EVC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .feat_vec(feat_vec),
    .core_result(core_result),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_class(m_class),
    .m_err(m_err)
  );

  assign core_result = ~(^feat_vec);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int qm(int d);
    int r;
`ifdef TNN_PACKER_ROUND_EN
    r = (d + 2**(IN_W-4)) / 2**(IN_W-3);
    if (r > 7) r = 7;
`else
    r = d / 2**(IN_W-3);
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int slots[NFEAT];
  int n_beats;
  int now_edge;
  int res_edge;
  bit pending;
  int e_class;
  int e_err;

  function automatic int packed_vec();
    int v;
    v = 0;
    for (int k = 0; k < NFEAT; k++)
      v = v | (slots[k] << (3*k));
    return v;
  endfunction

  function automatic int parity_inv(int v);
    int p;
    p = 0;
    for (int b = 0; b < 3*NFEAT; b++)
      p = p ^ ((v >> b) & 1);
    return 1 - p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NFEAT; k++) slots[k] = 0;
      n_beats  = 0;
      now_edge = 0;
      res_edge = 0;
      pending  = 0;
      e_class  = 0;
      e_err    = 0;
    end else begin
      now_edge++;
      if (!pending && s_valid) begin
        slots[n_beats] = qm(int'(s_data));
        if (s_last)
          for (int k = n_beats + 1; k < NFEAT; k++) slots[k] = 0;
        if (s_last || n_beats == NFEAT - 1) begin
          e_class  = parity_inv(packed_vec());
          e_err    = ((s_last && n_beats < NFEAT - 1) ||
                      (!s_last && n_beats == NFEAT - 1)) ? 1 : 0;
          pending  = 1;
          res_edge = now_edge + EVC + 1;
          n_beats  = 0;
        end else begin
          n_beats++;
        end
      end else if (pending && now_edge > res_edge && m_ready) begin
        pending = 0;
      end
    end
  end

  always @(negedge clk) begin
    int exp_mv;
    exp_mv = (pending && now_edge >= res_edge) ? 1 : 0;
    chk("s_ready", int'(s_ready), pending ? 0 : 1);
    chk("m_valid", int'(m_valid), exp_mv);
    chk("feat_vec", int'(feat_vec), packed_vec());
    if (exp_mv == 1) begin
      chk("m_class", int'(m_class), e_class);
      chk("m_err", int'(m_err), e_err);
    end
  end

  task automatic send(input int d, input bit last);
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_data  = IN_W'(d);
    s_last  = last;
    for (int i = 0; i < 100; i++) begin
      if (s_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("send_wait", int'(ok), 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("valid_wait", int'(ok), 1);
  endtask

  task automatic drain();
    wait_valid();
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  initial begin
    int q30;
`ifdef TNN_PACKER_ROUND_EN
    q30 = 2;
`else
    q30 = 1;
`endif
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_feat_vec", int'(feat_vec), 0);
    chk("rst_m_err", int'(m_err), 0);
    chk("rst_m_class", int'(m_class), 0);

    send('hE0, 0);
    send('h20, 0);
    send('h40, 0);
    send('h60, 0);
    send('h80, 0);
    send('hA0, 1);
    chk("lat_edge1", int'(m_valid), 0);
    @(negedge clk);
    #1;
    chk("lat_edge2", int'(m_valid), 0);
    @(negedge clk);
    #1;
    chk("lat_edge3", int'(m_valid), 1);
    chk("full_vec", int'(feat_vec), 'o543217);
    chk("full_class", int'(m_class), 1);
    chk("full_err", int'(m_err), 0);
    drain();

    send('h20, 0);
    send('h40, 0);
    send('h60, 1);
    wait_valid();
    chk("short_vec", int'(feat_vec), 'o000321);
    chk("short_err", int'(m_err), 1);
    chk("short_ready", int'(s_ready), 0);
    drain();

    for (int i = 0; i < NFEAT; i++)
      send(int'($urandom_range(255)), i == NFEAT - 1);
    wait_valid();
    s_valid = 1'b1;
    s_data  = IN_W'('hE0);
    s_last  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    chk("hold_valid", int'(m_valid), 1);
    chk("hold_ready", int'(s_ready), 0);
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    m_ready = 1'b0;
    chk("hs_ready", int'(s_ready), 1);
    chk("hs_valid", int'(m_valid), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    s_valid = 1'b0;
    chk("first_accept", int'(feat_vec[2:0]), 7);

    send('h11, 0);
    send('h22, 0);
    send('h33, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(s_ready), 1);
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_vec", int'(feat_vec), 0);
    chk("mid_rst_err", int'(m_err), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NFEAT; i++)
      send(i * 'h20, i == NFEAT - 1);
    wait_valid();
    chk("post_rst_vec", int'(feat_vec), 'o543210);
    chk("post_rst_err", int'(m_err), 0);
    drain();

    send('h30, 0);
    send('hF0, 1);
    wait_valid();
    chk("q_30", int'(feat_vec[2:0]), q30);
    chk("q_F0", int'(feat_vec[5:3]), 7);
    chk("q_err", int'(m_err), 1);
    drain();

    repeat (3000) begin
      @(negedge clk);
      #1;
      s_valid = ($urandom_range(3) != 0);
      s_data  = IN_W'($urandom_range(255));
      s_last  = ($urandom_range(4) == 0);
      m_ready = ($urandom_range(1) == 1);
    end
    @(negedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
